// File: rtl/dop_pkg.sv
// Shared DoP definitions for the DSD-over-PCM packer.
// Holds the marker bytes, the word and payload widths, the default silence
// payload, the transmit word layout and the marker sequencing helper.
package dop_pkg;

    localparam int unsigned DOP_WORD_W    = 24;
    localparam int unsigned DOP_PAYLOAD_W = 16;
    localparam int unsigned DOP_MARKER_W  = 8;

    localparam logic [DOP_MARKER_W-1:0]  DOP_MARKER_A     = 8'h05;
    localparam logic [DOP_MARKER_W-1:0]  DOP_MARKER_B     = 8'hFA;
    localparam logic [DOP_PAYLOAD_W-1:0] DOP_IDLE_DEFAULT = 16'h6969;

    // One DoP word as sent on the wire: marker byte first, then payload.
    typedef struct packed {
        logic [DOP_MARKER_W-1:0]  marker;
        logic [DOP_PAYLOAD_W-1:0] payload;
    } dop_word_t;

    // Markers alternate 0x05 / 0xFA from one frame to the next.
    function automatic logic [DOP_MARKER_W-1:0] dop_next_marker(
        input logic [DOP_MARKER_W-1:0] marker
    );
        return (marker == DOP_MARKER_A) ? DOP_MARKER_B : DOP_MARKER_A;
    endfunction

endpackage

// File: rtl/dop_word_fifo.sv
// Synchronous FIFO of 16-bit DoP payloads.
// Ports: clk, rst_n (async active-low), push/wdata (write), pop/rdata
// (show-ahead read), full, empty, level (occupancy 0..FIFO_DEPTH).
// A pop on empty is ignored. A push on full is accepted only when a pop
// happens in the same cycle.
module dop_word_fifo
    import dop_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic                          pop,
    input  logic [DOP_PAYLOAD_W-1:0]      wdata,
    output logic [DOP_PAYLOAD_W-1:0]      rdata,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [DOP_PAYLOAD_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]         wptr;
    logic [PTR_W-1:0]         rptr;
    logic                     do_push;
    logic                     do_pop;

    // Status flags come straight from the registered occupancy.
    always_comb begin
        full    = (level == LVL_W'(FIFO_DEPTH));
        empty   = (level == '0);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        rdata   = mem[rptr];
    end

    // Storage array; no reset needed because level gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers wrap naturally since the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (do_pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
        end
    end

endmodule

// File: rtl/dsd_dop_packer.sv
// DSD-over-PCM packer: packs 16 DSD bits per DoP word, queues the words and
// sends them as an I2S master stream clocked by bclk.
// Ports: bclk, rst_n (async active-low), dsd_in/dsd_valid (bit stream),
// flags_clr (clears sticky flags), ws_out/sdata_out (I2S, MSB first, one-bit
// delay), overflow/underflow (sticky), fifo_level (queued words).
// Optional macro DOP_RIGHT_DUP_EN: when defined the right slot repeats the
// left-slot word; when undefined the right slot is silent.
module dsd_dop_packer
    import dop_pkg::*;
#(
    parameter int unsigned              FIFO_DEPTH   = 4,
    parameter int unsigned              SLOT_BITS    = 32,
    parameter logic [DOP_PAYLOAD_W-1:0] IDLE_PATTERN = DOP_IDLE_DEFAULT
) (
    input  logic                        bclk,
    input  logic                        rst_n,
    input  logic                        dsd_in,
    input  logic                        dsd_valid,
    input  logic                        flags_clr,
    output logic                        ws_out,
    output logic                        sdata_out,
    output logic                        overflow,
    output logic                        underflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int unsigned FRAME_LEN = 2 * SLOT_BITS;
    localparam int unsigned FCNT_W    = $clog2(FRAME_LEN);
    localparam int unsigned BIT_IDX_W = $clog2(DOP_WORD_W);

    logic [FCNT_W-1:0]        fcnt;
    logic [FCNT_W-1:0]        fcnt_nxt;
    logic [FCNT_W-1:0]        slot_pos;
    logic [BIT_IDX_W-1:0]     bit_idx;
    logic                     right_nxt;
    logic                     slot_en;
    logic                     sdata_nxt;
    logic [14:0]              shift_reg;
    logic [3:0]               pack_cnt;
    logic [DOP_PAYLOAD_W-1:0] packed_word;
    logic                     word_done;
    logic                     load;
    logic                     ov_evt;
    logic                     uf_evt;
    dop_word_t                tx_word;
    logic [DOP_MARKER_W-1:0]  next_marker;
    logic [DOP_PAYLOAD_W-1:0] fifo_rdata;
    logic                     fifo_full;
    logic                     fifo_empty;

    // Packing, frame timing and flag events.
    // A full FIFO at the load point always pops, so the push still fits.
    always_comb begin
        word_done   = dsd_valid && (pack_cnt == 4'd15);
        packed_word = {shift_reg, dsd_in};
        load        = (fcnt == FCNT_W'(FRAME_LEN - 1));
        fcnt_nxt    = load ? '0 : fcnt + FCNT_W'(1);
        ov_evt      = word_done && fifo_full && !load;
        uf_evt      = load && fifo_empty;
    end

    // Serial bit for the next cycle; slot position 0 is the I2S delay bit.
    always_comb begin
        right_nxt = (fcnt_nxt >= FCNT_W'(SLOT_BITS));
        slot_pos  = right_nxt ? (fcnt_nxt - FCNT_W'(SLOT_BITS)) : fcnt_nxt;
`ifdef DOP_RIGHT_DUP_EN
        slot_en   = 1'b1;
`else
        slot_en   = !right_nxt;
`endif
        bit_idx   = '0;
        sdata_nxt = 1'b0;
        if (slot_en && (slot_pos != '0) && (slot_pos <= FCNT_W'(DOP_WORD_W))) begin
            bit_idx   = BIT_IDX_W'(DOP_WORD_W - 32'(slot_pos));
            sdata_nxt = tx_word[bit_idx];
        end
    end

    // Packer, frame counter, serialiser output, word load and sticky flags.
    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt        <= '0;
            ws_out      <= 1'b0;
            sdata_out   <= 1'b0;
            shift_reg   <= '0;
            pack_cnt    <= '0;
            tx_word     <= {DOP_MARKER_A, IDLE_PATTERN};
            next_marker <= DOP_MARKER_B;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            fcnt      <= fcnt_nxt;
            ws_out    <= right_nxt;
            sdata_out <= sdata_nxt;
            if (dsd_valid) begin
                shift_reg <= packed_word[14:0];
                pack_cnt  <= pack_cnt + 4'd1;
            end
            if (load) begin
                tx_word     <= {next_marker, fifo_empty ? IDLE_PATTERN : fifo_rdata};
                next_marker <= dop_next_marker(next_marker);
            end
            overflow  <= (overflow && !flags_clr) || ov_evt;
            underflow <= (underflow && !flags_clr) || uf_evt;
        end
    end

    dop_word_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (bclk),
        .rst_n (rst_n),
        .push  (word_done),
        .pop   (load),
        .wdata (packed_word),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

endmodule

// File: tb/tb_dsd_dop_packer.sv
// Self-checking bench for dsd_dop_packer. A queue-based reference model
// tracks the bit stream, the word FIFO and the word sent in each frame; a
// capture process rebuilds every I2S frame from the pins for the tasks to
// compare.
module tb_dsd_dop_packer;

    localparam int unsigned DEPTH = 4;
    localparam int          SLOT  = 32;
    localparam int          FRAME = 64;
    localparam logic [15:0] IDLE  = 16'h6969;
`ifdef DOP_RIGHT_DUP_EN
    localparam bit DUP = 1'b1;
`else
    localparam bit DUP = 1'b0;
`endif

    typedef struct packed {
        logic [23:0] l;
        logic [23:0] r;
        logic        bad;
    } frame_t;

    logic       bclk      = 1'b0;
    logic       rst_n     = 1'b0;
    logic       dsd_in    = 1'b0;
    logic       dsd_valid = 1'b0;
    logic       flags_clr = 1'b0;
    logic       ws_out;
    logic       sdata_out;
    logic       overflow;
    logic       underflow;
    logic [2:0] fifo_level;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    int          pos;
    logic [15:0] fq[$];
    bit          bits_q[$];
    logic [23:0] exp_q[$];
    logic [7:0]  m_marker;
    bit          m_ov;
    bit          m_uf;
    bit          mdone;
    logic [15:0] mword;
    logic [15:0] mpay;

    // Capture state.
    frame_t      cap_q[$];
    logic [23:0] cl;
    logic [23:0] cr;
    logic        cbad;
    int          sp;

    always #5 bclk = ~bclk;

    dsd_dop_packer #(
        .FIFO_DEPTH   (DEPTH),
        .SLOT_BITS    (SLOT),
        .IDLE_PATTERN (IDLE)
    ) dut (
        .bclk       (bclk),
        .rst_n      (rst_n),
        .dsd_in     (dsd_in),
        .dsd_valid  (dsd_valid),
        .flags_clr  (flags_clr),
        .ws_out     (ws_out),
        .sdata_out  (sdata_out),
        .overflow   (overflow),
        .underflow  (underflow),
        .fifo_level (fifo_level)
    );

    // Reference model: 16 bits make a word (first bit is MSB); at the last
    // cycle of a frame the oldest word (or idle) is taken first, then any
    // newly completed word is queued or dropped if the queue is full.
    initial begin
        pos = 0;
        forever begin
            @(posedge bclk or negedge rst_n);
            if (!rst_n) begin
                pos = 0;
                fq.delete();
                bits_q.delete();
                exp_q.delete();
                exp_q.push_back({8'h05, IDLE});
                m_marker = 8'hFA;
                m_ov = 1'b0;
                m_uf = 1'b0;
            end else begin
                mdone = 1'b0;
                if (flags_clr) begin
                    m_ov = 1'b0;
                    m_uf = 1'b0;
                end
                if (dsd_valid) begin
                    bits_q.push_back(dsd_in);
                    if (bits_q.size() == 16) begin
                        mword = '0;
                        for (int i = 0; i < 16; i++) mword[15-i] = bits_q[i];
                        bits_q.delete();
                        mdone = 1'b1;
                    end
                end
                if (pos == FRAME - 1) begin
                    if (fq.size() > 0) begin
                        mpay = fq.pop_front();
                    end else begin
                        mpay = IDLE;
                        m_uf = 1'b1;
                    end
                    exp_q.push_back({m_marker, mpay});
                    m_marker = (m_marker == 8'h05) ? 8'hFA : 8'h05;
                end
                if (mdone) begin
                    if (fq.size() < int'(DEPTH)) fq.push_back(mword);
                    else m_ov = 1'b1;
                end
                pos = (pos + 1) % FRAME;
            end
        end
    end

    // Frame capture: rebuild left/right words and flag any stray bit or
    // wrong word-select level.
    initial begin
        forever begin
            @(negedge bclk);
            if (!rst_n) begin
                cap_q.delete();
                cl = '0;
                cr = '0;
                cbad = 1'b0;
            end else begin
                if (ws_out !== (pos >= SLOT)) cbad = 1'b1;
                sp = pos % SLOT;
                if (sp >= 1 && sp <= 24) begin
                    if (pos < SLOT) cl[24-sp] = sdata_out;
                    else cr[24-sp] = sdata_out;
                end else if (sdata_out !== 1'b0) begin
                    cbad = 1'b1;
                end
                if (pos == FRAME - 1) begin
                    cap_q.push_back(frame_t'{l: cl, r: cr, bad: cbad});
                    cl = '0;
                    cr = '0;
                    cbad = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge bclk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge bclk);
        #1;
        rst_n = 1'b0;
        dsd_valid = 1'b0;
        flags_clr = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge bclk);
        n_cmp += 5;
        if (ws_out !== 1'b0) begin n_bad++; $display("FAIL reset_ws got %b want 0", ws_out); end
        if (sdata_out !== 1'b0) begin n_bad++; $display("FAIL reset_sdata got %b want 0", sdata_out); end
        if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b want 0", overflow); end
        if (underflow !== 1'b0) begin n_bad++; $display("FAIL reset_udf got %b want 0", underflow); end
        if (fifo_level !== 3'd0) begin n_bad++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    endtask

    task automatic test_idle();
        do_reset();
        repeat (4 * FRAME) tick();
        n_cmp++;
        if (cap_q.size() < 4) begin n_bad++; $display("FAIL idle_frames got %0d want 4", cap_q.size()); end
        for (int i = 0; i < cap_q.size(); i++) begin
            n_cmp += 2;
            if (cap_q[i] !== frame_t'{l: exp_q[i], r: (DUP ? exp_q[i] : 24'h0), bad: 1'b0}) begin
                n_bad++;
                $display("FAIL idle_frame[%0d] got l=%h r=%h bad=%b want l=%h", i, cap_q[i].l, cap_q[i].r, cap_q[i].bad, exp_q[i]);
            end
            if (cap_q[i].l !== {(i % 2 == 1) ? 8'hFA : 8'h05, IDLE}) begin
                n_bad++;
                $display("FAIL idle_marker[%0d] got %h", i, cap_q[i].l);
            end
        end
        n_cmp += 3;
        if (underflow !== 1'b1) begin n_bad++; $display("FAIL idle_udf got %b want 1", underflow); end
        if (overflow !== 1'b0) begin n_bad++; $display("FAIL idle_ovf got %b want 0", overflow); end
        if (fifo_level !== 3'd0) begin n_bad++; $display("FAIL idle_level got %0d want 0", fifo_level); end
    endtask

    task automatic test_sparse();
        logic [15:0] pat;
        int          max_lvl;
        pat = 16'hF0F0;
        max_lvl = 0;
        do_reset();
        for (int c = 0; c < 8 * FRAME; c++) begin
            dsd_valid = (c % 4 == 0);
            dsd_in = pat[15 - ((c / 4) % 16)];
            tick();
            if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
        end
        dsd_valid = 1'b0;
        for (int i = 0; i < cap_q.size(); i++) begin
            n_cmp++;
            if (cap_q[i] !== frame_t'{l: exp_q[i], r: (DUP ? exp_q[i] : 24'h0), bad: 1'b0}) begin
                n_bad++;
                $display("FAIL sparse_frame[%0d] got l=%h r=%h bad=%b want l=%h", i, cap_q[i].l, cap_q[i].r, cap_q[i].bad, exp_q[i]);
            end
            if (i >= 1) begin
                n_cmp++;
                if (cap_q[i].l !== {(i % 2 == 1) ? 8'hFA : 8'h05, 16'hF0F0}) begin
                    n_bad++;
                    $display("FAIL sparse_payload[%0d] got %h want F0F0", i, cap_q[i].l);
                end
            end
        end
        n_cmp += 2;
        if (underflow !== 1'b0) begin n_bad++; $display("FAIL sparse_udf got %b want 0", underflow); end
        if (max_lvl > 2) begin n_bad++; $display("FAIL sparse_level got max %0d want <=2", max_lvl); end
    endtask

    task automatic test_burst();
        int max_lvl;
        max_lvl = 0;
        do_reset();
        for (int c = 0; c < 200; c++) begin
            dsd_valid = 1'b1;
            dsd_in = 1'($urandom);
            tick();
            if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
            n_cmp++;
            if (fifo_level !== 3'(fq.size())) begin
                n_bad++;
                $display("FAIL burst_level c=%0d got %0d want %0d", c, fifo_level, fq.size());
            end
        end
        dsd_valid = 1'b0;
        repeat (8 * FRAME) tick();
        for (int i = 0; i < cap_q.size(); i++) begin
            n_cmp++;
            if (cap_q[i] !== frame_t'{l: exp_q[i], r: (DUP ? exp_q[i] : 24'h0), bad: 1'b0}) begin
                n_bad++;
                $display("FAIL burst_frame[%0d] got l=%h r=%h bad=%b want l=%h", i, cap_q[i].l, cap_q[i].r, cap_q[i].bad, exp_q[i]);
            end
        end
        n_cmp += 4;
        if (overflow !== 1'b1) begin n_bad++; $display("FAIL burst_ovf got %b want 1", overflow); end
        if (max_lvl != int'(DEPTH)) begin n_bad++; $display("FAIL burst_maxlvl got %0d want %0d", max_lvl, DEPTH); end
        if (fifo_level !== 3'd0) begin n_bad++; $display("FAIL burst_drain got %0d want 0", fifo_level); end
        if (underflow !== m_uf) begin n_bad++; $display("FAIL burst_udf got %b want %b", underflow, m_uf); end
    endtask

    task automatic test_coincide();
        do_reset();
        for (int c = 0; c < FRAME; c++) begin
            dsd_valid = (c < 15) || (c == FRAME - 1);
            dsd_in = 1'($urandom);
            if (c == FRAME - 1) begin
                n_cmp++;
                if (underflow !== 1'b0) begin n_bad++; $display("FAIL coin_udf_before got %b want 0", underflow); end
            end
            tick();
        end
        dsd_valid = 1'b0;
        n_cmp += 2;
        if (underflow !== 1'b1) begin n_bad++; $display("FAIL coin_udf got %b want 1", underflow); end
        if (fifo_level !== 3'd1) begin n_bad++; $display("FAIL coin_level got %0d want 1", fifo_level); end
        repeat (2 * FRAME) tick();
        n_cmp++;
        if (cap_q.size() < 3 || cap_q[1].l !== {8'hFA, IDLE}) begin
            n_bad++;
            $display("FAIL coin_idle_word frames=%0d want %h", cap_q.size(), {8'hFA, IDLE});
        end
        for (int i = 0; i < cap_q.size(); i++) begin
            n_cmp++;
            if (cap_q[i] !== frame_t'{l: exp_q[i], r: (DUP ? exp_q[i] : 24'h0), bad: 1'b0}) begin
                n_bad++;
                $display("FAIL coin_frame[%0d] got l=%h r=%h bad=%b want l=%h", i, cap_q[i].l, cap_q[i].r, cap_q[i].bad, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] w;
        logic        b;
        do_reset();
        repeat (FRAME) tick();
        for (int c = 0; c < 40; c++) begin
            dsd_valid = (c >= 33);
            dsd_in = 1'($urandom);
            tick();
        end
        dsd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp += 4;
        if (ws_out !== 1'b0) begin n_bad++; $display("FAIL mid_ws got %b want 0", ws_out); end
        if (sdata_out !== 1'b0) begin n_bad++; $display("FAIL mid_sdata got %b want 0", sdata_out); end
        if (underflow !== 1'b0) begin n_bad++; $display("FAIL mid_udf got %b want 0", underflow); end
        if (fifo_level !== 3'd0) begin n_bad++; $display("FAIL mid_level got %0d want 0", fifo_level); end
        repeat (2) tick();
        rst_n = 1'b1;
        w = '0;
        for (int c = 0; c < 16; c++) begin
            b = 1'($urandom);
            w[15-c] = b;
            dsd_valid = 1'b1;
            dsd_in = b;
            tick();
        end
        dsd_valid = 1'b0;
        repeat (3 * FRAME - 16) tick();
        n_cmp += 2;
        if (cap_q.size() < 2 || cap_q[0].l !== {8'h05, IDLE}) begin
            n_bad++;
            $display("FAIL mid_first_frame frames=%0d want %h", cap_q.size(), {8'h05, IDLE});
        end
        if (cap_q.size() < 2 || cap_q[1].l !== {8'hFA, w}) begin
            n_bad++;
            $display("FAIL mid_fresh_word frames=%0d want %h", cap_q.size(), {8'hFA, w});
        end
        for (int i = 0; i < cap_q.size(); i++) begin
            n_cmp++;
            if (cap_q[i] !== frame_t'{l: exp_q[i], r: (DUP ? exp_q[i] : 24'h0), bad: 1'b0}) begin
                n_bad++;
                $display("FAIL mid_frame[%0d] got l=%h r=%h bad=%b want l=%h", i, cap_q[i].l, cap_q[i].r, cap_q[i].bad, exp_q[i]);
            end
        end
    endtask

    task automatic test_flags_clr();
        bit done_a;
        bit done_b;
        done_a = 1'b0;
        done_b = 1'b0;
        do_reset();
        dsd_valid = 1'b1;
        for (int c = 0; c < 400 && !done_b; c++) begin
            dsd_in = 1'($urandom);
            if (!done_a && m_ov && bits_q.size() != 15 && pos != FRAME - 1) begin
                flags_clr = 1'b1;
                tick();
                flags_clr = 1'b0;
                done_a = 1'b1;
                n_cmp++;
                if (overflow !== 1'b0) begin n_bad++; $display("FAIL clr_alone got %b want 0", overflow); end
            end else if (done_a && bits_q.size() == 15 && fq.size() == DEPTH && pos != FRAME - 1) begin
                flags_clr = 1'b1;
                tick();
                flags_clr = 1'b0;
                done_b = 1'b1;
                n_cmp++;
                if (overflow !== 1'b1) begin n_bad++; $display("FAIL clr_vs_set got %b want 1", overflow); end
            end else begin
                tick();
            end
        end
        dsd_valid = 1'b0;
        n_cmp++;
        if (!done_b) begin n_bad++; $display("FAIL clr_timeout got done=%b want 1", done_b); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_sparse();
        test_burst();
        test_coincide();
        test_reset_mid();
        test_flags_clr();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
